// File: rtl/alu_execute_stage.sv
// Execute stage for the mini MIPS datapath: valid/ready ALU with registered Result/Zero.
// Define ALU_EXEC_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts run one bit per cycle.
module alu_execute_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero
);
    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpNor = 3'b111;

    logic             accept;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             slt_lt;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    assign shamt  = OpB[ShW-1:0];
    assign slt_lt = $signed(OpA) < $signed(OpB);
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            OpAdd:   alu_res = OpA + OpB;
            OpSub:   alu_res = OpA - OpB;
            OpAnd:   alu_res = OpA & OpB;
            OpOr:    alu_res = OpA | OpB;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            OpSll:   alu_res = OpA << shamt;
            OpSrl:   alu_res = OpA >> shamt;
`else
            // Only reached for a zero shift amount; nonzero amounts use the iterative path.
            OpSll:   alu_res = OpA;
            OpSrl:   alu_res = OpA;
`endif
            OpNor:   alu_res = ~(OpA | OpB);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_BARREL_SHIFT_EN

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

`else

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, work_shifted;
    logic [ShW-1:0]   cnt_q, cnt_d;
    logic             dir_right_q, dir_right_d;
    logic             is_shift;

    assign is_shift     = (ALUOp == OpSll) || (ALUOp == OpSrl);
    assign work_shifted = dir_right_q ? (work_q >> 1) : (work_q << 1);
    assign in_ready     = (state_q == StIdle) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        dir_right_d = dir_right_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d      = OpA;
                        cnt_d       = shamt;
                        dir_right_d = (ALUOp == OpSrl);
                        out_valid_d = 1'b0;
                        state_d     = StShift;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            StShift: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - 1'b1;
                // Last step publishes the shifted value directly, saving a cycle.
                if (cnt_q == ShW'(1)) begin
                    result_d    = work_shifted;
                    zero_d      = (work_shifted == '0);
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            dir_right_q <= dir_right_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

`endif

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: driver pushes expected results, monitor pops on handshake.
module tb_alu_execute_stage;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    localparam bit Barrel = 1'b1;
`else
    localparam bit Barrel = 1'b0;
`endif

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpNor = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ALUOp = 3'b000;
    logic [15:0] OpA = 16'h0000;
    logic [15:0] OpB = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Result;
    logic        Zero;

    int total = 0;
    int bad = 0;
    logic [15:0] sb[$];

    alu_execute_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .OpA       (OpA),
        .OpB       (OpB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {16'h0, Result}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check("result", {16'h0, Result}, {16'h0, e});
                check("zero", {31'h0, Zero}, {31'h0, (e == 16'h0)});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_r, input bit push, output int waited);
        waited = 0;
        in_valid = 1'b1;
        ALUOp = op;
        OpA = a;
        OpB = b;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'h0, 32'h1);
        end else begin
            @(posedge clk);
            if (push) sb.push_back(exp_r);
        end
        #1;
        in_valid = 1'b0;
        ALUOp = ~op;
        OpA = ~a;
        OpB = ~b;
    endtask

    task automatic op1(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_r);
        int w;
        issue(op, a, b, exp_r, 1'b1, w);
        check({name, "_lat1"}, {31'h0, out_valid}, 32'h1);
    endtask

    task automatic shift_op(input string name, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp_r);
        int w;
        int n;
        n = int'(b[3:0]);
        issue(op, a, b, exp_r, 1'b1, w);
        if (!Barrel && n != 0) begin
            for (int i = 0; i < n; i++) begin
                check({name, "_busy_ready"}, {31'h0, in_ready}, 32'h0);
                check({name, "_busy_valid"}, {31'h0, out_valid}, 32'h0);
                @(posedge clk);
                #1;
            end
        end
        check({name, "_done"}, {31'h0, out_valid}, 32'h1);
        check({name, "_value"}, {16'h0, Result}, {16'h0, exp_r});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #3;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", {16'h0, Result}, 32'h0);
        check("rst_zero", {31'h0, Zero}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        op1("add_ovf", OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        op1("add_wrap", OpAdd, 16'hFFFF, 16'h0001, 16'h0000);
        op1("sub_zero", OpSub, 16'h0005, 16'h0005, 16'h0000);
        op1("sub_neg", OpSub, 16'h0003, 16'h0005, 16'hFFFE);
        op1("slt_neg", OpSlt, 16'hFFFF, 16'h0001, 16'h0001);
        op1("slt_pos", OpSlt, 16'h0001, 16'hFFFF, 16'h0000);
        op1("nor", OpNor, 16'h0F0F, 16'h00FF, 16'hF000);

        shift_op("sll4", OpSll, 16'h0001, 16'h0004, 16'h0010);
        shift_op("srl15", OpSrl, 16'h8000, 16'h000F, 16'h0001);
        shift_op("sll15", OpSll, 16'h0001, 16'h000F, 16'h8000);
        shift_op("srl4", OpSrl, 16'hF0F0, 16'h0004, 16'h0F0F);
        shift_op("sll_hiamt", OpSll, 16'h0003, 16'h0012, 16'h000C);
        shift_op("sll0", OpSll, 16'h1234, 16'h0000, 16'h1234);

        // Backpressure: hold the ADD result while a new op waits upstream.
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(OpAdd, 16'h0100, 16'h0023, 16'h0123, 1'b1, w);
        in_valid = 1'b1;
        ALUOp = OpOr;
        OpA = 16'h00F0;
        OpB = 16'h0F00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_result", {16'h0, Result}, 32'h0000_0123);
            check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            check("bp_ready_low", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OpOr, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b1, w);
        check("bp_same_cycle_accept", w, 0);
        check("bp_new_valid", {31'h0, out_valid}, 32'h1);
        check("bp_new_result", {16'h0, Result}, 32'h0000_0FF0);

        // Back-to-back stream: no stalls means one result per cycle.
        issue(OpAnd, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, w);
        check("stream0_nostall", w, 0);
        issue(OpOr, 16'h0001, 16'h0100, 16'h0101, 1'b1, w);
        check("stream1_nostall", w, 0);
        issue(OpAnd, 16'hFFFF, 16'h1234, 16'h1234, 1'b1, w);
        check("stream2_nostall", w, 0);
        issue(OpOr, 16'h8000, 16'h0008, 16'h8008, 1'b1, w);
        check("stream3_nostall", w, 0);
        check("stream_last_valid", {31'h0, out_valid}, 32'h1);

        // Reset in the middle of a 10-bit shift.
        issue(OpSll, 16'h0001, 16'h000A, 16'h0400, Barrel, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'h0, out_valid}, 32'h0);
        check("abort_result", {16'h0, Result}, 32'h0);
        check("abort_zero", {31'h0, Zero}, 32'h0);
        check("abort_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op1("post_rst_or", OpOr, 16'h00F0, 16'h000F, 16'h00FF);
        check("post_rst_value", {16'h0, Result}, 32'h0000_00FF);

        repeat (15) @(posedge clk);
        #1;
        check("drained_valid", {31'h0, out_valid}, 32'h0);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
